// File: rtl/phase_controller.sv
// Five-stage phase sequencer: one-hot stage enables, stall hold, memory-stage skip, stall timeout flag.
// Optional retired-instruction counter enabled by defining PHASE_CTRL_INSTRET_EN.
module phase_controller #(
    parameter int STALL_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        stall_fetch_i,
    input  logic        stall_decode_i,
    input  logic        stall_execute_i,
    input  logic        stall_memoryaccess_i,
    input  logic        mem_op_de_i,
    output logic        phase_fetch_o,
    output logic        phase_decode_o,
    output logic        phase_execute_o,
    output logic        phase_memoryaccess_o,
    output logic        phase_writeback_o,
    output logic        busy_o,
    output logic        inst_done_o,
    output logic        stall_timeout_o,
    output logic [63:0] instret_o
);

    // state     | meaning
    // S_IDLE    | no instruction in flight
    // S_FETCH   | fetch stage active
    // S_DECODE  | decode stage active
    // S_EXECUTE | execute stage active
    // S_MEMORY  | memory access stage active (loads/stores only)
    // S_WRITEBK | register-file write, always one cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(STALL_TIMEOUT);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 stall_cur;
    logic                 timeout_hit;

    // A stalled cycle is exactly a cycle where the state holds, so the
    // counter only needs the active stall to decide between count and clear.
    always_comb begin
        state_d   = state_q;
        stall_cur = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                stall_cur = stall_fetch_i;
                if (!stall_fetch_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                stall_cur = stall_decode_i;
                if (!stall_decode_i) state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                stall_cur = stall_execute_i;
                if (!stall_execute_i) state_d = mem_op_de_i ? S_MEMORY : S_WRITEBK;
            end
            S_MEMORY: begin
                stall_cur = stall_memoryaccess_i;
                if (!stall_memoryaccess_i) state_d = S_WRITEBK;
            end
            S_WRITEBK: begin
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        stall_cnt_d = '0;
        if (stall_cur) stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CNT_ONE;
        timeout_hit = stall_cur && (stall_cnt_d == TIMEOUT_VAL);
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q              <= S_IDLE;
            stall_cnt_q          <= '0;
            phase_fetch_o        <= 1'b0;
            phase_decode_o       <= 1'b0;
            phase_execute_o      <= 1'b0;
            phase_memoryaccess_o <= 1'b0;
            phase_writeback_o    <= 1'b0;
            busy_o               <= 1'b0;
            inst_done_o          <= 1'b0;
            stall_timeout_o      <= 1'b0;
        end else begin
            state_q              <= state_d;
            stall_cnt_q          <= stall_cnt_d;
            phase_fetch_o        <= (state_d == S_FETCH);
            phase_decode_o       <= (state_d == S_DECODE);
            phase_execute_o      <= (state_d == S_EXECUTE);
            phase_memoryaccess_o <= (state_d == S_MEMORY);
            phase_writeback_o    <= (state_d == S_WRITEBK);
            busy_o               <= (state_d != S_IDLE);
            inst_done_o          <= (state_d == S_WRITEBK);
            stall_timeout_o      <= stall_timeout_o | timeout_hit;
        end
    end

`ifdef PHASE_CTRL_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= 64'd0;
        end else if (state_q == S_WRITEBK) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_phase_controller.sv
// Scoreboard bench for phase_controller: directed test-plan scenarios then randomized segments.
module tb_phase_controller;

    localparam int TO   = 16;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        sf = 1'b0, sd = 1'b0, se = 1'b0, sm = 1'b0, mo = 1'b0;
    logic        ph_f, ph_d, ph_e, ph_m, ph_w, busy, done, tmo_o;
    logic [63:0] instret;

    always #5 clk = ~clk;

    phase_controller #(.STALL_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .run_i               (run),
        .stall_fetch_i       (sf),
        .stall_decode_i      (sd),
        .stall_execute_i     (se),
        .stall_memoryaccess_i(sm),
        .mem_op_de_i         (mo),
        .phase_fetch_o       (ph_f),
        .phase_decode_o      (ph_d),
        .phase_execute_o     (ph_e),
        .phase_memoryaccess_o(ph_m),
        .phase_writeback_o   (ph_w),
        .busy_o              (busy),
        .inst_done_o         (done),
        .stall_timeout_o     (tmo_o),
        .instret_o           (instret)
    );

    typedef struct {
        logic [7:0]  flags;   // {F,D,E,M,W,busy,done,timeout}
        logic [63:0] iret;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: stage number 0=idle, 1=fetch .. 5=writeback
    int          m_ph   = 0;
    int          m_scnt = 0;
    bit          m_tmo  = 1'b0;
    logic [63:0] m_iret = 64'd0;

    task automatic model_edge();
        logic stall_in [1:4];
        stall_in[1] = sf; stall_in[2] = sd; stall_in[3] = se; stall_in[4] = sm;
        if (rst) begin
            m_ph = 0; m_scnt = 0; m_tmo = 1'b0; m_iret = 64'd0;
        end else if (m_ph == 0) begin
            m_ph = run ? 1 : 0;
        end else if (m_ph == 5) begin
`ifdef PHASE_CTRL_INSTRET_EN
            m_iret = m_iret + 64'd1;
`endif
            m_ph = run ? 1 : 0;
        end else if (stall_in[m_ph]) begin
            if (m_scnt < CMAX) m_scnt = m_scnt + 1;
            if (m_scnt == TO) m_tmo = 1'b1;
        end else begin
            m_scnt = 0;
            if (m_ph == 3) m_ph = mo ? 4 : 5;
            else           m_ph = m_ph + 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t       e;
        logic [4:0] onehot;
        onehot = 5'b00000;
        if (m_ph != 0) begin
            onehot = 5'b10000;
            onehot = onehot >> (m_ph - 1);
        end
        e.flags = {onehot, (m_ph != 0), (m_ph == 5), m_tmo};
        e.iret  = m_iret;
        return e;
    endfunction

    task automatic step(input logic r, input logic rn, input logic f, input logic d,
                        input logic x, input logic m, input logic op);
        #1;
        rst = r; run = rn; sf = f; sd = d; se = x; sm = m; mo = op;
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_out());
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {ph_f, ph_d, ph_e, ph_m, ph_w, busy, done, tmo_o};
                n_checks++;
                if (act !== e.flags || instret !== e.iret) begin
                    n_err++;
                    $display("FAIL outputs t=%0t got flags=%b instret=%0d, expected flags=%b instret=%0d",
                             $time, act, instret, e.flags, e.iret);
                end
            end
        end
    end

    initial begin
        int p;
        // Reset
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        // Back-to-back non-memory instructions
        repeat (10) step(0, 1, 0, 0, 0, 0, 0);
        // Load/store instructions
        repeat (11) step(0, 1, 0, 0, 0, 0, 1);
        // Drain to idle, then decode stall for 3 cycles
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        // Long memory stall crosses the timeout; flag must stay sticky
        repeat (30) step(0, 1, 0, 0, 0, 1, 1);
        repeat (8) step(0, 0, 0, 0, 0, 0, 0);
        // run dropped mid-instruction completes it, then restart
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);
        // Reset while in memory stage
        repeat (8) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10 && m_ph != 4; i++) step(0, 0, 0, 0, 0, 1, 1);
        if (m_ph != 4) begin
            n_checks++; n_err++;
            $display("FAIL reach_memory model stage=%0d expected 4", m_ph);
        end
        step(1, 1, 0, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        // Randomized segments with varying stall density
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 25;
                2:       p = 60;
                default: p = 100;
            endcase
            for (int c = 0; c < 100; c++) begin
                step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p),
                     ($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p),
                     1'($urandom_range(0, 1)));
            end
        end
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++; n_err++;
            $display("FAIL drain got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
